fifo_wr_arbiter: RTL and testbench

//  Round-robin, packet-atomic arbiter that shares the single write port of the 8-bit sync FIFO

---
 rtl/fifo_arb_pkg.sv | 24 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 39 +++
 rtl/fifo_wr_arbiter.sv | 142 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
//   Shared definitions for the FIFO write-port arbiter: default data width,
//   the largest supported requester count, the grant index width and the
//   two-state FSM encoding. Also provides the modulo helper used by the
//   round-robin picker.
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

  localparam int DW       = 8;   // matches the FIFO buf_in width
  localparam int NREQ_MAX = 8;   // grant index is 3 bits wide
  localparam int GW       = 3;   // width of grant_id / rr pointer

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  // Position "off" steps after "base" on a ring of n entries.
  function automatic int wrap_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin selector. Scans req starting one position after
//   ptr (ptr+1, ptr+2, ... wrapping at NREQ) and returns the first asserted
//   index. The entry at ptr itself is examined last, so the previous owner has
//   the lowest priority.
// Ports
//   req      in   NREQ  request vector
//   ptr      in   3     index of the most recent owner
//   gnt_idx  out  3     winning index (0 when nothing requests)
//   any      out  1     at least one request is asserted
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]                req,
  input  logic [fifo_arb_pkg::GW-1:0]    ptr,
  output logic [fifo_arb_pkg::GW-1:0]    gnt_idx,
  output logic                           any
);

  import fifo_arb_pkg::*;

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Walk the ring from the farthest offset back to the nearest one; the
  // nearest asserted request is written last and therefore wins.
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[IW'(wrap_idx(int'(ptr), k, NREQ))]) begin
        gnt_idx = GW'(wrap_idx(int'(ptr), k, NREQ));
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin, packet-atomic arbiter sharing the single write port of the
//   8-bit sync FIFO among NREQ byte producers. A granted requester keeps the
//   port until its last byte (or until MAXLEN beats), so packets never
//   interleave inside the FIFO. The data/ready path is combinational: the
//   FIFO samples the write on the same edge as the producer handshake.
//
// Ports
//   clk         in   1        system clock, rising edge
//   rst         in   1        asynchronous reset, active high
//   req_valid   in   NREQ     per-requester byte valid
//   req_data    in   NREQ*DW  per-requester byte, requester i at [i*DW +: DW]
//   req_last    in   NREQ     last byte of packet, qualified by req_valid
//   req_ready   out  NREQ     per-requester accept
//   fifo_full   in   1        FIFO full flag
//   fifo_wr_en  out  1        FIFO write strobe
//   fifo_din    out  DW       FIFO write data
//   grant_id    out  3        current owner, valid while busy
//   busy        out  1        packet in progress
//   beat_cnt    out  LW       beats accepted in the current packet
//   len_err     out  1        one-cycle pulse: packet cut at MAXLEN
//
// State | meaning
// ------+----------------------------------------------------------------
// IDLE  | no owner; pick next requester round-robin (one bubble cycle)
// LOCK  | grant_id owns the FIFO port until last byte or MAXLEN beats
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NREQ   = 2,
  parameter int DW     = fifo_arb_pkg::DW,
  parameter int MAXLEN = 16,
  parameter int LW     = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DW-1:0]     req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   fifo_full,
  output logic                   fifo_wr_en,
  output logic [DW-1:0]          fifo_din,
  output logic [2:0]             grant_id,
  output logic                   busy,
  output logic [LW-1:0]          beat_cnt,
  output logic                   len_err
);

  import fifo_arb_pkg::*;

  arb_state_e       state_q;
  logic [GW-1:0]    rr_ptr_q;
  logic [GW-1:0]    grant_q;
  logic [LW-1:0]    beat_q;
  logic [LW-1:0]    beat_d;
  logic             len_err_q;

  logic             own_valid;
  logic             own_last;
  logic             xfer;
  logic             at_max;
  logic             pkt_end;
  logic             pick_any;
  logic [GW-1:0]    pick_idx;

  rr_pick #(
    .NREQ    (NREQ)
  ) u_rr_pick (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // Owner-side view of the requester signals plus the FIFO data mux.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    fifo_din  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q == GW'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        fifo_din  = req_data[i*DW +: DW];
      end
    end
  end

  // Only the owner sees ready, and only while the FIFO has room.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = (state_q == ST_LOCK) && (grant_q == GW'(i)) && !fifo_full;
    end
  end

  assign xfer    = (state_q == ST_LOCK) && own_valid && !fifo_full;
  assign beat_d  = beat_q + LW'(1);
  // The beat being accepted now is the MAXLEN-th one.
  assign at_max  = (beat_q == LW'(MAXLEN - 1));
  assign pkt_end = xfer && (own_last || at_max);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= GW'(NREQ - 1);
      grant_q   <= '0;
      beat_q    <= '0;
      len_err_q <= 1'b0;
    end else begin
      len_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            grant_q <= pick_idx;
            beat_q  <= '0;
            state_q <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (xfer) begin
            beat_q <= beat_d;
          end
          if (pkt_end) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= grant_q;
            len_err_q <= !own_last;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign fifo_wr_en = xfer;
  assign grant_id   = grant_q;
  assign busy       = (state_q == ST_LOCK);
  assign beat_cnt   = beat_q;
  assign len_err    = len_err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Directed bench for fifo_wr_arbiter (NREQ=2, MAXLEN=16). Producers are byte
//   queues that hold valid/data/last until accepted. A reference model tracks
//   the owner, round-robin pointer and beat count as plain integers and is
//   checked against the DUT on every falling edge; every byte the DUT writes
//   is logged so each scenario can compare FIFO order and write timing with
//   hand-computed sequences.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int NREQ   = 2;
  localparam int DW     = 8;
  localparam int MAXLEN = 16;
  localparam int LW     = 5;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*DW-1:0]   req_data = '0;
  logic [NREQ-1:0]      req_last = '0;
  logic [NREQ-1:0]      req_ready;
  logic                 fifo_full = 1'b0;
  logic                 fifo_wr_en;
  logic [DW-1:0]        fifo_din;
  logic [2:0]           grant_id;
  logic                 busy;
  logic [LW-1:0]        beat_cnt;
  logic                 len_err;

  fifo_wr_arbiter #(
    .NREQ       (NREQ),
    .DW         (DW),
    .MAXLEN     (MAXLEN),
    .LW         (LW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .grant_id   (grant_id),
    .busy       (busy),
    .beat_cnt   (beat_cnt),
    .len_err    (len_err)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_lenerr = 0;

  logic [8:0] q0[$];   // {last, data}
  logic [8:0] q1[$];
  logic [7:0] wlog[$];
  int         wcyc[$];
  logic [NREQ-1:0] acc = '0;

  // reference model state
  bit m_busy   = 1'b0;
  int m_owner  = 0;
  int m_ptr    = NREQ - 1;
  int m_beats  = 0;
  bit m_lenerr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic present();
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    if (q0.size() > 0) begin
      req_valid[0]   = 1'b1;
      req_data[7:0]  = q0[0][7:0];
      req_last[0]    = q0[0][8];
    end
    if (q1.size() > 0) begin
      req_valid[1]   = 1'b1;
      req_data[15:8] = q1[0][7:0];
      req_last[1]    = q1[0][8];
    end
  endtask

  task automatic push(input int r, input int n, input int base, input bit with_last);
    logic [8:0] v;
    for (int k = 0; k < n; k++) begin
      v = {with_last && (k == n - 1), 8'(base + k)};
      if (r == 0) q0.push_back(v);
      else        q1.push_back(v);
    end
  endtask

  // Producers: retire the byte accepted on this edge, then show the next one.
  initial forever begin
    @(posedge clk);
    #1;
    if (acc[0] && q0.size() > 0) void'(q0.pop_front());
    if (acc[1] && q1.size() > 0) void'(q1.pop_front());
    acc = '0;
    present();
  end

  // Per-cycle compare against the model, then advance the model to the
  // state it must hold after the coming rising edge.
  initial forever begin
    logic [NREQ-1:0] exp_ready;
    bit              exp_wr;
    bit              next_lenerr;
    @(negedge clk);
    cyc++;
    if (rst) begin
      m_busy   = 1'b0;
      m_owner  = 0;
      m_ptr    = NREQ - 1;
      m_beats  = 0;
      m_lenerr = 1'b0;
    end
    exp_ready = '0;
    if (m_busy && !fifo_full) exp_ready[m_owner] = 1'b1;
    exp_wr = m_busy && req_valid[m_owner] && !fifo_full;
    chk("busy", busy, m_busy);
    chk("req_ready", req_ready, exp_ready);
    chk("fifo_wr_en", fifo_wr_en, exp_wr);
    chk("len_err", len_err, m_lenerr);
    if (m_busy || rst) begin
      chk("grant_id", grant_id, m_owner);
      chk("beat_cnt", beat_cnt, m_beats);
    end
    if (m_busy) begin
      chk("fifo_din", fifo_din, m_owner == 0 ? req_data[7:0] : req_data[15:8]);
    end
    if (!rst && fifo_wr_en) begin
      wlog.push_back(fifo_din);
      wcyc.push_back(cyc);
    end
    if (len_err) n_lenerr++;
    acc = req_valid & req_ready;
    if (!rst) begin
      next_lenerr = 1'b0;
      if (!m_busy) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (!m_busy && req_valid[(m_ptr + k) % NREQ]) begin
            m_busy  = 1'b1;
            m_owner = (m_ptr + k) % NREQ;
            m_beats = 0;
          end
        end
      end else if (req_valid[m_owner] && !fifo_full) begin
        m_beats++;
        if (req_last[m_owner] || m_beats == MAXLEN) begin
          m_busy      = 1'b0;
          m_ptr       = m_owner;
          next_lenerr = !req_last[m_owner];
        end
      end
      m_lenerr = next_lenerr;
    end
  end

  task automatic wait_log(input int n, input int budget, input string name);
    int k = 0;
    while (wlog.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk(name, wlog.size() >= n, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst       = 1'b1;
    fifo_full = 1'b0;
    q0.delete();
    q1.delete();
    wlog.delete();
    wcyc.delete();
    n_lenerr = 0;
    present();
    @(posedge clk);
    #2;
  endtask

  task automatic release_rst();
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  logic [7:0] exp2[12] = '{8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1, 8'hB2,
                           8'hA3, 8'hA4, 8'hA5, 8'hB3, 8'hB4, 8'hB5};
  logic [7:0] exp6[8]  = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2, 8'hA3, 8'hB3};

  initial begin
    // 1: reset with both requesters valid, then requester 0 wins first
    push(0, 1, 'hA0, 1'b1);
    push(1, 1, 'hB0, 1'b1);
    present();
    @(negedge clk);
    chk("t1_rst_busy", busy, 1'b0);
    chk("t1_rst_ready", req_ready, 2'b00);
    chk("t1_rst_wr", fifo_wr_en, 1'b0);
    chk("t1_rst_grant", grant_id, 3'd0);
    chk("t1_rst_beat", beat_cnt, 5'd0);
    chk("t1_rst_lenerr", len_err, 1'b0);
    release_rst();
    @(negedge clk);
    @(negedge clk);
    chk("t1_busy", busy, 1'b1);
    chk("t1_grant", grant_id, 3'd0);
    wait_log(2, 20, "t1_timeout");
    chk("t1_first", wlog[0], 8'hA0);
    chk("t1_second", wlog[1], 8'hB0);

    // 2: back-to-back 3-byte packets alternate, one idle cycle between
    do_reset();
    push(0, 3, 'hA0, 1'b1);
    push(0, 3, 'hA3, 1'b1);
    push(1, 3, 'hB0, 1'b1);
    push(1, 3, 'hB3, 1'b1);
    present();
    release_rst();
    wait_log(12, 80, "t2_timeout");
    for (int i = 0; i < 12; i++) chk($sformatf("t2_order%0d", i), wlog[i], exp2[i]);
    chk("t2_gap_in_pkt", wcyc[1] - wcyc[0], 1);
    chk("t2_gap_between", wcyc[3] - wcyc[2], 2);

    // 3: FIFO full during beat 2 of a requester-1 packet
    do_reset();
    push(1, 4, 'hB0, 1'b1);
    present();
    release_rst();
    wait_log(2, 20, "t3_timeout_a");
    #2;
    fifo_full = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t3_full_wr", fifo_wr_en, 1'b0);
      chk("t3_full_ready", req_ready, 2'b00);
      chk("t3_full_din", fifo_din, 8'hB2);
      chk("t3_full_grant", grant_id, 3'd1);
      chk("t3_full_busy", busy, 1'b1);
    end
    @(posedge clk);
    #2;
    fifo_full = 1'b0;
    wait_log(4, 20, "t3_timeout_b");
    repeat (4) @(posedge clk);
    chk("t3_count", wlog.size(), 4);
    chk("t3_byte2", wlog[2], 8'hB2);
    chk("t3_byte3", wlog[3], 8'hB3);

    // 4: 20 bytes with no last are cut at 16; requester 1 goes next
    do_reset();
    push(0, 20, 'h40, 1'b0);
    push(1, 2, 'hB0, 1'b1);
    present();
    release_rst();
    wait_log(22, 100, "t4_timeout");
    repeat (4) @(posedge clk);
    chk("t4_count", wlog.size(), 22);
    chk("t4_last_of_cut", wlog[15], 8'h4F);
    chk("t4_next_owner0", wlog[16], 8'hB0);
    chk("t4_next_owner1", wlog[17], 8'hB1);
    chk("t4_resume", wlog[18], 8'h50);
    chk("t4_lenerr_pulses", n_lenerr, 1);
    @(negedge clk);
    chk("t4_stall_busy", busy, 1'b1);
    chk("t4_stall_beats", beat_cnt, 5'd4);

    // 5: reset after beat 2 of 5 abandons the packet
    do_reset();
    push(0, 5, 'h60, 1'b1);
    present();
    release_rst();
    wait_log(2, 20, "t5_timeout_a");
    #2;
    rst = 1'b1;
    q0.delete();
    q1.delete();
    present();
    #1;
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_wr", fifo_wr_en, 1'b0);
    push(1, 1, 'hB0, 1'b1);
    push(0, 1, 'h70, 1'b1);
    present();
    repeat (2) @(posedge clk);
    chk("t5_no_more_writes", wlog.size(), 2);
    #2;
    rst = 1'b0;
    wait_log(4, 20, "t5_timeout_b");
    chk("t5_first_after", wlog[2], 8'h70);
    chk("t5_second_after", wlog[3], 8'hB0);

    // 6: single-beat packets alternate, one write every two cycles
    do_reset();
    for (int k = 0; k < 4; k++) begin
      push(0, 1, 'hA0 + k, 1'b1);
      push(1, 1, 'hB0 + k, 1'b1);
    end
    present();
    release_rst();
    wait_log(8, 40, "t6_timeout");
    for (int i = 0; i < 8; i++) chk($sformatf("t6_order%0d", i), wlog[i], exp6[i]);
    for (int i = 0; i < 7; i++) chk($sformatf("t6_spacing%0d", i), wcyc[i+1] - wcyc[i], 2);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

endmodule
